// File: rtl/ibex_instr_mem_responder_if.sv
// Instruction-fetch bus between the core (master) and the memory responder
// (slave). Also carries the preload write port and the debug occupancy count.
//   instr_req_i/instr_addr_i     : fetch request and byte address
//   instr_gnt_o                  : request accepted this cycle
//   instr_rvalid_o/rdata_o/err_o : in-order response, one cycle each
//   load_en_i/addr_i/data_i      : preload write port (word index)
//   outstanding_o                : granted-but-unanswered count
interface ibex_instr_mem_responder_if #(
  parameter int unsigned MemWords = 1024
);
  logic                        instr_req_i;
  logic [31:0]                 instr_addr_i;
  logic                        instr_gnt_o;
  logic                        instr_rvalid_o;
  logic [31:0]                 instr_rdata_o;
  logic                        instr_err_o;
  logic                        load_en_i;
  logic [$clog2(MemWords)-1:0] load_addr_i;
  logic [31:0]                 load_data_i;
  logic [2:0]                  outstanding_o;

  modport slave (
    input  instr_req_i, instr_addr_i, load_en_i, load_addr_i, load_data_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, outstanding_o
  );

  modport master (
    output instr_req_i, instr_addr_i, load_en_i, load_addr_i, load_data_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, outstanding_o
  );
endinterface

// File: rtl/ibex_instr_mem_responder.sv
// Responder end of the instruction-fetch req/gnt/rvalid bus, served from a
// preloadable word array. Granted requests are queued (depth MaxOutstanding),
// aged by a per-entry latency counter and answered strictly in grant order
// through registered rvalid/rdata/err outputs.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : ibex_instr_mem_responder_if.slave (fetch bus, preload, debug count)
// Optional feature macro IBEX_INSTR_RESP_STALL_EN: a 16-bit LFSR injects
// pseudo-random grant stalls and response-issue stalls.
module ibex_instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  ibex_instr_mem_responder_if.slave       bus
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam int unsigned PW       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [2:0]  MAX_CNT  = 3'(MaxOutstanding);
  localparam logic [2:0]  LAT_PRE  = 3'(RespLatency - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MaxOutstanding - 1);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [2:0]  lat;
  } entry_t;

  logic [31:0]   mem [MemWords];
  entry_t        q     [MaxOutstanding];
  entry_t        q_nxt [MaxOutstanding];
  entry_t        new_e;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic [29:0]   word;
  logic          word_err;
  logic          push, pop, grant_ok, issue_ok;
  logic          rvalid_q, err_q;
  logic [31:0]   rdata_q;

  // Stall injection
`ifdef IBEX_INSTR_RESP_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign grant_ok = (lfsr[1:0] != 2'b00);
  assign issue_ok = (lfsr[3:2] != 2'b00);
`else
  assign grant_ok = 1'b1;
  assign issue_ok = 1'b1;
`endif

  // Grant only looks at the registered count: a pop this cycle does not
  // free a slot until the next cycle. Held low while in reset.
  assign bus.instr_gnt_o = rst_ni & bus.instr_req_i & (count < MAX_CNT) & grant_ok;
  assign push = bus.instr_gnt_o;
  assign pop  = (count != 3'd0) & (q[rd_ptr].lat == 3'd0) & issue_ok;

  assign word     = bus.instr_addr_i[31:2];
  assign word_err = ({2'b00, word} >= 32'(MemWords));

  always_comb begin
    new_e.err  = word_err;
    new_e.data = word_err ? 32'h0 : mem[word[AW-1:0]];
    new_e.lat  = LAT_PRE;
  end

  // Backing array: not reset. Reads above see the pre-edge value, so a
  // grant colliding with a preload write to the same word returns old data.
  always_ff @(posedge clk_i) begin
    if (bus.load_en_i) mem[bus.load_addr_i] <= bus.load_data_i;
  end

  // Queue next state: every entry ages (saturating at 0); the write slot
  // takes the freshly captured entry. A push never lands on the head being
  // popped because a full queue cannot be granted.
  always_comb begin
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      q_nxt[i] = q[i];
      if (q[i].lat != 3'd0) q_nxt[i].lat = q[i].lat - 3'd1;
      if (push && (wr_ptr == PW'(i))) q_nxt[i] = new_e;
    end
  end

  if (ResetAll) begin : g_q_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(MaxOutstanding); i++) q[i] <= '0;
      end else begin
        for (int i = 0; i < int'(MaxOutstanding); i++) q[i] <= q_nxt[i];
      end
    end
  end else begin : g_q_norst
    always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) q[i] <= q_nxt[i];
    end
  end

  // Control state and registered response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count    <= 3'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      count    <= count + {2'b00, push} - {2'b00, pop};
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      rvalid_q <= pop;
      rdata_q  <= pop ? q[rd_ptr].data : 32'h0;
      err_q    <= pop & q[rd_ptr].err;
    end
  end

  assign bus.instr_rvalid_o = rvalid_q;
  assign bus.instr_rdata_o  = rdata_q;
  assign bus.instr_err_o    = err_q;
  assign bus.outstanding_o  = count;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder. u0: MaxOutstanding=2, RespLatency=1;
// u1: MaxOutstanding=2, RespLatency=3. Directed vector table on u0, hand
// sequences on u1 (back-pressure, mid-operation reset), and a 200-request
// random scoreboard run on u0 that also works with stall injection enabled.
module tb_ibex_instr_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_instr_mem_responder_if #(.MemWords(1024)) b0();
  ibex_instr_mem_responder_if #(.MemWords(1024)) b1();

  ibex_instr_mem_responder #(.MemWords(1024), .MaxOutstanding(2), .RespLatency(1))
    u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0.slave));
  ibex_instr_mem_responder #(.MemWords(1024), .MaxOutstanding(2), .RespLatency(3))
    u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        ld;
    logic [9:0]  ldi;
    logic [31:0] ldd;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic [2:0]  out;
  } vec_t;

  function automatic vec_t mk(logic req, logic [31:0] addr, logic ld, logic [9:0] ldi,
                              logic [31:0] ldd, logic gnt, logic rv, logic [31:0] rd,
                              logic err, logic [2:0] out);
    vec_t v;
    v.req = req; v.addr = addr; v.ld = ld; v.ldi = ldi; v.ldd = ldd;
    v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err; v.out = out;
    return v;
  endfunction

  // Reference copy of array words 0..15 used by the random run
  logic [31:0] mdl [16];

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          g;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   ngnt = 0, gstall = 0, rstall = 0, last_rsp = 0;

  // Scoreboard on u0: responses checked first (a grant seen now cannot
  // be answered before the next edge), then the grant of this cycle queued.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b0.instr_rvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          exp_t h;
          int   earliest;
          h = exp_q.pop_front();
          chk("rand_rdata", b0.instr_rdata_o, h.d);
          chk("rand_err", {31'd0, b0.instr_err_o}, {31'd0, h.e});
          earliest = (h.g + 1 > last_rsp + 1) ? h.g + 1 : last_rsp + 1;
          if (cyc > earliest) rstall++;
          last_rsp = cyc;
        end
      end
      if (b0.instr_req_i && !b0.instr_gnt_o && b0.outstanding_o < 3'd2) gstall++;
      if (b0.instr_req_i && b0.instr_gnt_o) begin
        exp_t n;
        logic [29:0] w;
        w = b0.instr_addr_i[31:2];
        n.g = cyc + 1;
        n.e = (w >= 30'd1024);
        n.d = n.e ? 32'h0 : mdl[w[3:0]];
        exp_q.push_back(n);
        ngnt++;
      end
    end
  end

  // Request on u1 until granted (bounded); leaves req low after the grant edge
  task automatic req1(input logic [31:0] a, input string nm);
    logic g;
    g = 1'b0;
    for (int i = 0; i < 50 && !g; i++) begin
      @(posedge clk); #1;
      b1.instr_req_i = 1'b1; b1.instr_addr_i = a;
      @(negedge clk);
      g = b1.instr_gnt_o;
    end
    @(posedge clk); #1;
    b1.instr_req_i = 1'b0;
    chk(nm, {31'd0, g}, 32'd1);
  endtask

  // u1 single cycle: drive, then check at negedge; rdata only when valid
  task automatic step1(input string nm, input logic req, input logic [31:0] a,
                       input logic eg, input logic erv, input logic [31:0] erd,
                       input logic [2:0] eout);
    @(posedge clk); #1;
    b1.instr_req_i = req; b1.instr_addr_i = a;
    @(negedge clk);
    chk({nm, "_gnt"}, {31'd0, b1.instr_gnt_o}, {31'd0, eg});
    chk({nm, "_rvalid"}, {31'd0, b1.instr_rvalid_o}, {31'd0, erv});
    chk({nm, "_out"}, {29'd0, b1.outstanding_o}, {29'd0, eout});
    if (erv) chk({nm, "_rdata"}, b1.instr_rdata_o, erd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    logic found;

    b0.instr_req_i = 1'b0; b0.instr_addr_i = '0; b0.load_en_i = 1'b0;
    b0.load_addr_i = '0;   b0.load_data_i = '0;
    b1.instr_req_i = 1'b0; b1.instr_addr_i = '0; b1.load_en_i = 1'b0;
    b1.load_addr_i = '0;   b1.load_data_i = '0;

    // Reset state, with a request pending to show grant is blocked
    #2;
    b0.instr_req_i = 1'b1; b0.instr_addr_i = 32'h10;
    #1;
    chk("rst_gnt", {31'd0, b0.instr_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, b0.instr_rvalid_o}, 32'd0);
    chk("rst_rdata", b0.instr_rdata_o, 32'd0);
    chk("rst_err", {31'd0, b0.instr_err_o}, 32'd0);
    chk("rst_out", {29'd0, b0.outstanding_o}, 32'd0);
    b0.instr_req_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Preload words 0..15 and 1023 on both instances
    for (int i = 0; i < 16; i++) mdl[i] = 32'h1000_0000 + 32'(i * 32'h111);
    mdl[4] = 32'h0000_0013;
    mdl[5] = 32'h0041_0113;
    mdl[8] = 32'h0000_0001;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      b0.load_en_i = 1'b1; b1.load_en_i = 1'b1;
      b0.load_addr_i = (i == 16) ? 10'd1023 : 10'(i);
      b0.load_data_i = (i == 16) ? 32'hCAFE_F00D : mdl[i];
      b1.load_addr_i = b0.load_addr_i;
      b1.load_data_i = b0.load_data_i;
    end
    @(posedge clk); #1;
    b0.load_en_i = 1'b0; b1.load_en_i = 1'b0;

`ifndef IBEX_INSTR_RESP_STALL_EN
    // Directed table on u0 (latency 1): expected values are those seen at the
    // negedge of the cycle in which the row's inputs are driven.
    //            req addr          ld ldi    ldd            gnt rv rd             err out
    tbl[0]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 0, 32'h0,         0, 3'd0);
    tbl[1]  = mk(1, 32'h10,       0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd0);
    tbl[2]  = mk(1, 32'h14,       0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd1);
    tbl[3]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'h0000_0013, 0, 3'd1);
    tbl[4]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'h0041_0113, 0, 3'd0);
    tbl[5]  = mk(1, 32'h1000,     0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd0);
    tbl[6]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 0, 32'h0,         0, 3'd1);
    tbl[7]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'h0,         1, 3'd0);
    tbl[8]  = mk(1, 32'h20,       1, 10'd8, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 3'd0);
    tbl[9]  = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 0, 32'h0,         0, 3'd1);
    tbl[10] = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'h0000_0001, 0, 3'd0);
    tbl[11] = mk(1, 32'h20,       0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd0);
    tbl[12] = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 0, 32'h0,         0, 3'd1);
    tbl[13] = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 3'd0);
    tbl[14] = mk(1, 32'hFFC,      0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd0);
    tbl[15] = mk(1, 32'h17,       0, 10'd0, 32'h0,         1, 0, 32'h0,         0, 3'd1);
    tbl[16] = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'hCAFE_F00D, 0, 3'd1);
    tbl[17] = mk(0, 32'h0,        0, 10'd0, 32'h0,         0, 1, 32'h0041_0113, 0, 3'd0);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      b0.instr_req_i = tbl[i].req; b0.instr_addr_i = tbl[i].addr;
      b0.load_en_i = tbl[i].ld; b0.load_addr_i = tbl[i].ldi; b0.load_data_i = tbl[i].ldd;
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i), {31'd0, b0.instr_gnt_o}, {31'd0, tbl[i].gnt});
      chk($sformatf("row%0d_rvalid", i), {31'd0, b0.instr_rvalid_o}, {31'd0, tbl[i].rv});
      chk($sformatf("row%0d_out", i), {29'd0, b0.outstanding_o}, {29'd0, tbl[i].out});
      if (tbl[i].rv) begin
        chk($sformatf("row%0d_rdata", i), b0.instr_rdata_o, tbl[i].rd);
        chk($sformatf("row%0d_err", i), {31'd0, b0.instr_err_o}, {31'd0, tbl[i].err});
      end
    end
    @(posedge clk); #1;
    b0.instr_req_i = 1'b0; b0.load_en_i = 1'b0;
    mdl[8] = 32'hDEAD_BEEF;

    // u1 (latency 3): third back-to-back request stalls until the first pops
    step1("bp_a", 1, 32'h10, 1, 0, 32'h0, 3'd0);
    step1("bp_b", 1, 32'h14, 1, 0, 32'h0, 3'd1);
    step1("bp_c", 1, 32'h20, 0, 0, 32'h0, 3'd2);
    step1("bp_d", 1, 32'h20, 0, 0, 32'h0, 3'd2);
    step1("bp_e", 1, 32'h20, 1, 1, 32'h0000_0013, 3'd1);
    step1("bp_f", 0, 32'h0,  0, 1, 32'h0041_0113, 3'd1);
    step1("bp_g", 0, 32'h0,  0, 0, 32'h0, 3'd1);
    step1("bp_h", 0, 32'h0,  0, 0, 32'h0, 3'd1);
    step1("bp_i", 0, 32'h0,  0, 1, 32'h0000_0001, 3'd0);
`endif

    // Mid-operation reset on u1 with requests in flight
    req1(32'h10, "mr_gnt0");
    req1(32'h14, "mr_gnt1");
`ifndef IBEX_INSTR_RESP_STALL_EN
    chk("mr_pre_out", {29'd0, b1.outstanding_o}, 32'd2);
`endif
    #1;
    rst_n = 1'b0;
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h10;
    #1;
    chk("mr_rst_gnt", {31'd0, b1.instr_gnt_o}, 32'd0);
    chk("mr_rst_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
    chk("mr_rst_out", {29'd0, b1.outstanding_o}, 32'd0);
    b1.instr_req_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mr_in_rst_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mr_post_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
      chk("mr_post_out", {29'd0, b1.outstanding_o}, 32'd0);
    end
    req1(32'h14, "mr_new_gnt");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = b1.instr_rvalid_o;
    end
    chk("mr_new_rvalid", {31'd0, found}, 32'd1);
    chk("mr_new_rdata", b1.instr_rdata_o, 32'h0041_0113);
    chk("mr_new_err", {31'd0, b1.instr_err_o}, 32'd0);

    // Random run on u0 against the scoreboard
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int i = 0; i < 4000 && ngnt < 200; i++) begin
      b0.instr_req_i = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0)
        b0.instr_addr_i = 32'h0000_1000 + 32'($urandom_range(0, 255) << 2);
      else
        b0.instr_addr_i = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    b0.instr_req_i = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("rand_grants", {31'd0, ngnt >= 200}, 32'd1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_out_idle", {29'd0, b0.outstanding_o}, 32'd0);
`ifdef IBEX_INSTR_RESP_STALL_EN
    chk("rand_gnt_stall_seen", {31'd0, gstall > 0}, 32'd1);
    chk("rand_rsp_stall_seen", {31'd0, rstall > 0}, 32'd1);
`else
    chk("rand_no_gnt_stall", 32'(gstall), 32'd0);
    chk("rand_no_rsp_stall", 32'(rstall), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
